// File: rtl/cipher_pkg.sv
// Shared constants, state encoding and character helpers for the Vigenere stream controller.
package cipher_pkg;

  localparam logic [7:0] ASCII_A   = 8'h41;
  localparam logic [7:0] ASCII_Z   = 8'h5A;
  localparam int         ALPHABET  = 26;
  localparam int         KEY_CHARS = 10;

  typedef enum logic [0:0] {
    NOKEY = 1'b0,
    RUN   = 1'b1
  } state_e;

  function automatic logic is_upper(input logic [7:0] c);
    return (c >= ASCII_A) && (c <= ASCII_Z);
  endfunction

endpackage

// File: rtl/shift_mod26.sv
// Mod-26 letter shift shared by the encrypt and decrypt paths.
module shift_mod26
  import cipher_pkg::*;
(
  input  logic [4:0] offset,
  input  logic [4:0] shiftAmt,
  input  logic       mode,
  output logic [4:0] wrapped
);

  logic [5:0] sum;
  logic [4:0] diff;

  // Operands are 0..25, so one conditional correction of 26 always lands back in range.
  always_comb begin
    sum     = {1'b0, offset} + {1'b0, shiftAmt};
    diff    = offset - shiftAmt;
    wrapped = '0;
    if (!mode) begin
      wrapped = (sum >= 6'(ALPHABET)) ? 5'(sum - 6'(ALPHABET)) : sum[4:0];
    end else begin
      wrapped = (offset < shiftAmt) ? diff + 5'(ALPHABET) : diff;
    end
  end

endmodule

// File: rtl/vigenere_stream_controller.sv
// Flow-controlled Vigenere sequencer: key register, rotating key index, one-deep output register.
// state | meaning
// NOKEY | no legal key loaded, input held off
// RUN   | legal key loaded, characters stream through
module vigenere_stream_controller #(
  parameter int KEY_CHARS = cipher_pkg::KEY_CHARS,
  parameter int CNT_W     = 16
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic [8*KEY_CHARS-1:0] key_in,
  input  logic [3:0]             key_len,
  input  logic                   key_load,
  input  logic                   mode,
  input  logic                   in_valid,
  input  logic [7:0]             in_char,
  output logic                   in_ready,
  output logic                   out_valid,
  output logic [7:0]             out_char,
  input  logic                   out_ready,
  output logic                   key_ok,
  output logic                   key_err,
  output logic [CNT_W-1:0]       letter_cnt
);

  import cipher_pkg::*;

  localparam logic [0:0] sNoKey = NOKEY;
  localparam logic [0:0] sRun   = RUN;

  logic [0:0]             state;
  logic [8*KEY_CHARS-1:0] keyReg;
  logic [3:0]             keyLen;
  logic [3:0]             idx;
  logic [3:0]             nextIdx;
  logic                   outValid;
  logic [7:0]             outChar;
  logic                   keyErr;
  logic [CNT_W-1:0]       letterCnt;

  logic       keyLegal;
  logic       loadOk;
  logic       xfer;
  logic       inIsLetter;
  logic [7:0] keyChar;
  logic [7:0] cipherChar;
  logic [4:0] shiftAmt;
  logic [4:0] letterOff;
  logic [4:0] wrapped;

  always_comb begin
    keyLegal = (key_len != 4'd0) && (int'(key_len) <= KEY_CHARS);
    for (int i = 0; i < KEY_CHARS; i++) begin
      if ((i < int'(key_len)) && !is_upper(key_in[8*i +: 8])) keyLegal = 1'b0;
    end
  end

  assign loadOk   = key_load && keyLegal;
  // A load cycle never accepts input, even when the load itself is rejected.
  assign in_ready = (state == sRun) && !key_load && (!outValid || out_ready);
  assign xfer     = in_valid && in_ready;

  assign inIsLetter = is_upper(in_char);
  assign keyChar    = keyReg[{idx, 3'b000} +: 8];
  assign shiftAmt   = 5'(keyChar - ASCII_A);
  assign letterOff  = 5'(in_char - ASCII_A);
  assign cipherChar = ASCII_A + {3'b000, wrapped};
  assign nextIdx    = (idx == keyLen - 4'd1) ? 4'd0 : idx + 4'd1;

  shift_mod26 uShift (
    .offset   (letterOff),
    .shiftAmt (shiftAmt),
    .mode     (mode),
    .wrapped  (wrapped)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= sNoKey;
      keyReg    <= '0;
      keyLen    <= '0;
      idx       <= '0;
      outValid  <= 1'b0;
      outChar   <= '0;
      keyErr    <= 1'b0;
      letterCnt <= '0;
    end else begin
      keyErr <= key_load && !keyLegal;
      if (loadOk) begin
        state     <= sRun;
        keyReg    <= key_in;
        keyLen    <= key_len;
        idx       <= '0;
        letterCnt <= '0;
        outValid  <= 1'b0;
      end else if (xfer) begin
        outValid <= 1'b1;
        outChar  <= inIsLetter ? cipherChar : in_char;
        if (inIsLetter) begin
          idx <= nextIdx;
          if (~&letterCnt) letterCnt <= letterCnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end else if (out_ready) begin
        outValid <= 1'b0;
      end
    end
  end

  assign out_valid  = outValid;
  assign out_char   = outChar;
  assign key_ok     = (state == sRun);
  assign key_err    = keyErr;
  assign letter_cnt = letterCnt;

endmodule

// File: tb/tb_vigenere_stream_controller.sv
// Self-checking bench: directed scenarios plus randomized traffic against a queue-free character model.
module tb_vigenere_stream_controller;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic [79:0] key_in;
  logic [3:0]  key_len;
  logic        key_load;
  logic        mode;
  logic        in_valid;
  logic [7:0]  in_char;
  logic        in_ready;
  logic        out_valid;
  logic [7:0]  out_char;
  logic        out_ready;
  logic        key_ok;
  logic        key_err;
  logic [15:0] letter_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [7:0] mKey [10];
  int         mLen, mIdx, mCnt;
  bit         mOk, mPend, mErr;
  logic [7:0] mOut;
  bit         expReady, obsReady;

  vigenere_stream_controller dut (
    .CLK(CLK), .RST_N(RST_N), .key_in(key_in), .key_len(key_len), .key_load(key_load),
    .mode(mode), .in_valid(in_valid), .in_char(in_char), .in_ready(in_ready),
    .out_valid(out_valid), .out_char(out_char), .out_ready(out_ready),
    .key_ok(key_ok), .key_err(key_err), .letter_cnt(letter_cnt)
  );

  always #5 CLK = ~CLK;

  function automatic logic [79:0] mk(input string s);
    logic [79:0] r = '0;
    for (int i = 0; i < s.len() && i < 10; i++) r[8*i +: 8] = s[i];
    return r;
  endfunction

  function automatic bit isUp(input logic [7:0] c);
    return (c >= 8'd65) && (c <= 8'd90);
  endfunction

  function automatic bit refLegal(input logic [79:0] kv, input logic [3:0] kl);
    if (kl < 1 || kl > 10) return 0;
    for (int i = 0; i < int'(kl); i++) if (!isUp(kv[8*i +: 8])) return 0;
    return 1;
  endfunction

  function automatic logic [7:0] refCipher(input logic [7:0] c, input logic [7:0] k, input bit m);
    int p = int'(c) - 65;
    int s = int'(k) - 65;
    int r = m ? (p - s + 26) % 26 : (p + s) % 26;
    return 8'(r + 65);
  endfunction

  task automatic model_reset();
    mLen = 0; mIdx = 0; mCnt = 0; mOk = 0; mPend = 0; mErr = 0; mOut = 8'h00;
  endtask

  // Drives one clock cycle and advances the model; comparisons are made by the callers.
  task automatic tick(input bit kl, input logic [79:0] kv, input logic [3:0] klen,
                      input bit iv, input logic [7:0] ic, input bit md, input bit ordy);
    key_load = kl; key_in = kv; key_len = klen;
    in_valid = iv; in_char = ic; mode = md; out_ready = ordy;
    #1;
    obsReady = in_ready;
    expReady = mOk && !kl && (!mPend || ordy);
    @(posedge CLK);
    mErr = 0;
    if (kl && refLegal(kv, klen)) begin
      for (int i = 0; i < 10; i++) mKey[i] = kv[8*i +: 8];
      mLen = int'(klen); mIdx = 0; mCnt = 0; mPend = 0; mOk = 1;
    end else begin
      mErr = kl;
      if (iv && expReady) begin
        mPend = 1;
        if (isUp(ic)) begin
          mOut = refCipher(ic, mKey[mIdx], md);
          mIdx = (mIdx + 1) % mLen;
          if (mCnt < 65535) mCnt++;
        end else begin
          mOut = ic;
        end
      end else if (ordy) begin
        mPend = 0;
      end
    end
    #1;
    key_load = 0;
  endtask

  task automatic test_reset();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (out_char !== 8'h00) begin errors++; $display("FAIL reset_out_char got %h want 00", out_char); end
    checks++; if (key_ok !== 1'b0 || key_err !== 1'b0) begin errors++; $display("FAIL reset_key_flags got ok=%b err=%b want 0 0", key_ok, key_err); end
    checks++; if (letter_cnt !== 16'd0) begin errors++; $display("FAIL reset_letter_cnt got %0d want 0", letter_cnt); end
  endtask

  task automatic test_illegal_nokey();
    tick(1, mk("A1"), 4'd2, 1, 8'h41, 0, 1);
    checks++; if (key_err !== 1'b1) begin errors++; $display("FAIL nokey_err_pulse got %b want 1", key_err); end
    checks++; if (key_ok !== 1'b0) begin errors++; $display("FAIL nokey_key_ok got %b want 0", key_ok); end
    tick(0, '0, 4'd0, 1, 8'h41, 0, 1);
    checks++; if (key_err !== 1'b0) begin errors++; $display("FAIL nokey_err_clear got %b want 0", key_err); end
    checks++; if (obsReady !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL nokey_blocked got rdy=%b ov=%b want 0 0", obsReady, out_valid); end
    tick(1, mk("ABCDEFGHIJ"), 4'd11, 0, 8'h00, 0, 1);
    checks++; if (key_err !== 1'b1 || key_ok !== 1'b0) begin errors++; $display("FAIL nokey_len11 got err=%b ok=%b want 1 0", key_err, key_ok); end
  endtask

  task automatic test_key_b();
    tick(1, mk("B"), 4'd1, 0, 8'h00, 0, 1);
    checks++; if (key_ok !== 1'b1 || key_err !== 1'b0) begin errors++; $display("FAIL keyb_load got ok=%b err=%b want 1 0", key_ok, key_err); end
    tick(0, '0, 4'd0, 1, 8'h41, 0, 1);
    checks++; if (obsReady !== 1'b1) begin errors++; $display("FAIL keyb_ready got %b want 1", obsReady); end
    checks++; if (out_valid !== 1'b1 || out_char !== 8'h42) begin errors++; $display("FAIL keyb_A got ov=%b ch=%h want 1 42", out_valid, out_char); end
    tick(0, '0, 4'd0, 1, 8'h5A, 0, 1);
    checks++; if (out_valid !== 1'b1 || out_char !== 8'h41) begin errors++; $display("FAIL keyb_Z got ov=%b ch=%h want 1 41", out_valid, out_char); end
    tick(0, '0, 4'd0, 0, 8'h00, 0, 1);
    checks++; if (out_valid !== 1'b0 || letter_cnt !== 16'd2) begin errors++; $display("FAIL keyb_drain got ov=%b cnt=%0d want 0 2", out_valid, letter_cnt); end
  endtask

  task automatic stream_check(input string name, input string src, input string want, input bit md);
    for (int i = 0; i < src.len(); i++) begin
      tick(0, '0, 4'd0, 1, src[i], md, 1);
      checks++;
      if (obsReady !== 1'b1 || out_valid !== 1'b1 || out_char !== want[i])
        begin errors++; $display("FAIL %s[%0d] got rdy=%b ov=%b ch=%h want 1 1 %h", name, i, obsReady, out_valid, out_char, want[i]); end
    end
  endtask

  task automatic test_lemon();
    tick(1, mk("LEMON"), 4'd5, 0, 8'h00, 0, 1);
    stream_check("enc_attack", "ATTACK", "LXFOPV", 0);
    checks++; if (letter_cnt !== 16'd6) begin errors++; $display("FAIL enc_cnt got %0d want 6", letter_cnt); end
    tick(1, mk("LEMON"), 4'd5, 0, 8'h00, 0, 1);
    checks++; if (out_valid !== 1'b0 || letter_cnt !== 16'd0) begin errors++; $display("FAIL reload_clear got ov=%b cnt=%0d want 0 0", out_valid, letter_cnt); end
    stream_check("dec_lxfopv", "LXFOPV", "ATTACK", 1);
  endtask

  task automatic test_passthrough();
    tick(1, mk("LEMON"), 4'd5, 0, 8'h00, 0, 1);
    stream_check("pass", "A T", "L X", 0);
    checks++; if (letter_cnt !== 16'd2) begin errors++; $display("FAIL pass_cnt got %0d want 2", letter_cnt); end
    stream_check("pass_lower", "a", "a", 0);
  endtask

  task automatic test_backpressure();
    tick(1, mk("LEMON"), 4'd5, 0, 8'h00, 0, 1);
    tick(0, '0, 4'd0, 1, 8'h41, 0, 1);
    for (int c = 0; c < 3; c++) begin
      tick(0, '0, 4'd0, 1, 8'h54, 0, 0);
      checks++;
      if (obsReady !== 1'b0 || out_valid !== 1'b1 || out_char !== 8'h4C)
        begin errors++; $display("FAIL bp_hold[%0d] got rdy=%b ov=%b ch=%h want 0 1 4c", c, obsReady, out_valid, out_char); end
    end
    stream_check("bp_resume", "TT", "XF", 0);
    checks++; if (letter_cnt !== 16'd3) begin errors++; $display("FAIL bp_cnt got %0d want 3", letter_cnt); end
  endtask

  task automatic test_illegal_run();
    tick(1, mk("LEMON"), 4'd5, 0, 8'h00, 0, 1);
    stream_check("ir_pre", "AT", "LX", 0);
    tick(1, mk("ZZZZZ"), 4'd0, 1, 8'h41, 0, 1);
    checks++; if (key_err !== 1'b1 || key_ok !== 1'b1 || obsReady !== 1'b0) begin errors++; $display("FAIL ir_len0 got err=%b ok=%b rdy=%b want 1 1 0", key_err, key_ok, obsReady); end
    tick(1, mk("Z1ZZZ"), 4'd5, 0, 8'h00, 0, 1);
    checks++; if (key_err !== 1'b1) begin errors++; $display("FAIL ir_badchar got %b want 1", key_err); end
    stream_check("ir_post", "TACK", "FOPV", 0);
    checks++; if (letter_cnt !== 16'd6) begin errors++; $display("FAIL ir_cnt got %0d want 6", letter_cnt); end
  endtask

  task automatic test_random();
    logic [79:0] kv;
    logic [3:0]  kl;
    logic [7:0]  ch;
    for (int n = 0; n < 600; n++) begin
      bit doLoad = (n == 0) || ($urandom_range(0, 49) == 0);
      kl = 4'($urandom_range(0, 11));
      if (n == 0) kl = 4'($urandom_range(1, 10));
      kv = '0;
      for (int i = 0; i < 10; i++)
        kv[8*i +: 8] = ($urandom_range(0, 29) == 0 && n != 0) ? 8'h31 : 8'($urandom_range(65, 90));
      ch = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(32, 126)) : 8'($urandom_range(65, 90));
      tick(doLoad, kv, kl, $urandom_range(0, 9) < 7, ch, 1'($urandom_range(0, 1)),
           $urandom_range(0, 9) < 7);
      checks++;
      if (obsReady !== expReady || out_valid !== mPend || key_ok !== mOk || key_err !== mErr
          || letter_cnt !== 16'(mCnt) || (mPend && out_char !== mOut))
        begin errors++; $display("FAIL rand[%0d] got rdy=%b ov=%b ch=%h ok=%b err=%b cnt=%0d want %b %b %h %b %b %0d",
                 n, obsReady, out_valid, out_char, key_ok, key_err, letter_cnt,
                 expReady, mPend, mOut, mOk, mErr, mCnt); end
    end
  endtask

  task automatic test_reset_pending();
    tick(1, mk("KEY"), 4'd3, 0, 8'h00, 0, 1);
    tick(0, '0, 4'd0, 1, 8'h41, 0, 0);
    checks++; if (out_valid !== 1'b1 || out_char !== 8'h4B) begin errors++; $display("FAIL rp_pending got ov=%b ch=%h want 1 4b", out_valid, out_char); end
    #2 RST_N = 0;
    #1;
    model_reset();
    checks++;
    if (out_valid !== 1'b0 || out_char !== 8'h00 || key_ok !== 1'b0 || in_ready !== 1'b0 || letter_cnt !== 16'd0)
      begin errors++; $display("FAIL rp_async got ov=%b ch=%h ok=%b rdy=%b cnt=%0d want 0 00 0 0 0", out_valid, out_char, key_ok, in_ready, letter_cnt); end
    @(posedge CLK); #1 RST_N = 1;
    tick(0, '0, 4'd0, 1, 8'h41, 0, 1);
    checks++; if (obsReady !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL rp_nokey got rdy=%b ov=%b want 0 0", obsReady, out_valid); end
    tick(1, mk("KEY"), 4'd3, 0, 8'h00, 0, 1);
    stream_check("rp_restart", "AAAA", "KEYK", 0);
  endtask

  initial begin
    RST_N = 0; key_in = '0; key_len = '0; key_load = 0; mode = 0;
    in_valid = 0; in_char = '0; out_ready = 0;
    model_reset();
    repeat (2) @(posedge CLK);
    #1 RST_N = 1;
    test_reset();
    test_illegal_nokey();
    test_key_b();
    test_lemon();
    test_passthrough();
    test_backpressure();
    test_illegal_run();
    test_random();
    test_reset_pending();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
